// File: rtl/cmp_seq_ctrl_if.sv
// Bundle of the operand, comparator-slice and verdict signals of cmp_seq_ctrl.
// slave is the controller's view; master is the environment (producer, slice, consumer).
// Input and output sides use independent valid/ready handshakes.
interface cmp_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [1:0]       cmp_a;
   logic [1:0]       cmp_b;
   logic [2:0]       cmp_result;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       result;
   logic             err;
   logic             busy;

   modport slave (
      input  in_valid, a_in, b_in, cmp_result, out_ready,
      output in_ready, cmp_a, cmp_b, out_valid, result, err, busy
   );

   modport master (
      output in_valid, a_in, b_in, cmp_result, out_ready,
      input  in_ready, cmp_a, cmp_b, out_valid, result, err, busy
   );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Digit-serial magnitude compare of two WIDTH-bit operands via an external 2-bit slice, MSB first.
// Latency: k+1 edges counting the accept edge (k = deciding digit, or WIDTH/2 without early exit).
// One job in flight: in_ready drops from accept until the verdict is consumed; the verdict holds while out_ready=0.
module cmp_seq_ctrl #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input logic         clk,
   input logic         rst,
   cmp_seq_ctrl_if.slave bus
);
   localparam int DIGITS = WIDTH / 2;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DIGITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] V_GT = 3'b001;
   localparam logic [2:0] V_EQ = 3'b010;
   localparam logic [2:0] V_LT = 3'b100;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_keep;     // first unequal verdict seen; 000 means none yet
   logic [2:0]       r_result;
   logic             r_err;

   logic w_onehot;
   logic w_accept;
   logic w_run;

   assign w_run    = (r_state == S_RUN);
   assign w_onehot = (bus.cmp_result == V_GT) || (bus.cmp_result == V_EQ) ||
                     (bus.cmp_result == V_LT);

   // in_ready is gated by rst so nothing can be accepted while reset is held
   assign bus.in_ready  = (r_state == S_IDLE) && !rst;
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.err       = r_err;
   assign bus.cmp_a     = w_run ? r_a[WIDTH-1 -: 2] : 2'b00;
   assign bus.cmp_b     = w_run ? r_b[WIDTH-1 -: 2] : 2'b00;

   // sequencer: latch operands, walk digits MSB first, hold verdict until consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_keep   <= 3'b000;
         r_result <= 3'b000;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a      <= bus.a_in;
                  r_b      <= bus.b_in;
                  r_cnt    <= CNT_INIT;
                  r_keep   <= 3'b000;
                  r_result <= 3'b000;
                  r_err    <= 1'b0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (!w_onehot) begin
                  // a broken slice code poisons the whole job, whatever the mode
                  r_err    <= 1'b1;
                  r_result <= 3'b000;
                  r_state  <= S_DONE;
               end else if (r_cnt == '0) begin
                  r_result <= (r_keep != 3'b000) ? r_keep : bus.cmp_result;
                  r_state  <= S_DONE;
               end else if (bus.cmp_result == V_EQ) begin
                  r_a   <= r_a << 2;
                  r_b   <= r_b << 2;
                  r_cnt <= r_cnt - 1'b1;
               end else if (EARLY_EXIT) begin
                  r_result <= bus.cmp_result;
                  r_state  <= S_DONE;
               end else begin
                  // the most significant unequal digit decides; later digits only run out the clock
                  if (r_keep == 3'b000) begin
                     r_keep <= bus.cmp_result;
                  end
                  r_a   <= r_a << 2;
                  r_b   <= r_b << 2;
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
